blockram_system_v2_leds: RTL and testbench
==========================================

# blockram_system_v2_leds

Avalon-MM slave output port driving the board LEDs from the Nios II data bus; the write-side counterpart of the switches input port in the same system. It holds an output data register with atomic set/clear aliases. A per-bit blink engine (prescaler plus half-period counter) toggles selected LEDs autonomously, so software does not have to poll a timer. Reads return register contents through a registered read mux with one cycle of latency.

## Interface
- PRESCALE, 50000: clk cycles per blink tick (1 ms at 50 MHz); legal range ≥2.
- WIDTH, 8: number of LED outputs, 1..16.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs on a clk edge with chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  LED drive, active-high.

## Operation
- Register map (unused bits: writes ignored, reads return 0):
  - 0 DATA, R/W, WIDTH bits.
  - 1 BLINK_EN, R/W, WIDTH bits.
  - 2 PERIOD, R/W, 16 bits: half-period in ticks.
  - 3 STATUS, R: bit0 = phase, bit1 = (PERIOD≠0).
  - 4 OUTSET, W: DATA |= writedata[WIDTH-1:0].
  - 5 OUTCLEAR, W: DATA &= ~writedata[WIDTH-1:0].
  - 6, 7: reserved; reads return 0 and writes are ignored.
- Reads from 4 and 5 return 0.
- out_port = DATA ^ (BLINK_EN & {WIDTH{phase}}). It is decoded combinationally from flops, with no further logic after the registers.
- Blink engine, active when PERIOD≠0:
  - presc counts 0..PRESCALE-1 and wraps; a tick is asserted on the wrap edge.
  - On each tick, hcnt increments. When a tick occurs with hcnt = PERIOD-1, hcnt returns to 0 and phase toggles.
- PERIOD=0: presc, hcnt and phase are held at 0, so out_port = DATA.
- Any write to PERIOD clears presc, hcnt and phase on the same edge, including a write of the current value.
- Writes to DATA, BLINK_EN, OUTSET and OUTCLEAR do not disturb the blink counters.

## Timing
- Reset (async assert, sync release): DATA, BLINK_EN, PERIOD, presc, hcnt, phase and readdata are all 0, so out_port = 0.
- Write at edge N: the register and out_port reflect the new value after edge N, i.e. zero wait states.
- readdata is updated every clk edge from the read mux at the current address, independent of chipselect and with no read strobe.
  - Read latency is 1 cycle: with address held, readdata is valid after the next edge.
- Write to address A at edge N with address held: readdata shows the pre-write value after edge N and the new value after edge N+1.
- Blink: after a PERIOD=P write at edge N, phase first toggles on edge N+P·PRESCALE, then every P·PRESCALE edges after that.
- Simultaneous events:
  - A PERIOD write on the same edge as a scheduled phase toggle: the write wins and phase becomes 0.
  - A write to hcnt-related state never collides, because only PERIOD writes clear the counters.
- Reducing PERIOD below the current hcnt cannot occur, since any PERIOD write clears hcnt.
- Reset asserted mid-blink: all state returns to reset values immediately, without waiting for a clk edge.

## Test plan
- Reset check:
  - Stimulus: assert reset_n=0 mid-run, with DATA=0xFF and blink active.
  - Required response: out_port=0x00 and readdata=0 with no clk edge. After release, reads of every address return 0.
- Write/readback and set/clear:
  - Stimulus: write DATA=0x5A, then OUTSET=0x81, then OUTCLEAR=0x18.
  - Required response: out_port goes 0x5A → 0xDB → 0xC3. Reading address 0 returns 0x000000C3; reading addresses 4 and 5 returns 0.
- Width masking:
  - Stimulus: write DATA=0xFFFFFFFF with WIDTH=8.
  - Required response: readback is 0x000000FF; writes to addresses 6 and 7 change no register.
- Blink timing (bench PRESCALE=4):
  - Stimulus: DATA=0x0F, BLINK_EN=0x03, PERIOD=3 written at edge N.
  - Required response: out_port=0x0F until edge N+12, then 0x0C, then 0x0F at N+24. STATUS bit0 tracks phase.
- PERIOD rewrite collision:
  - Stimulus: rewrite PERIOD=3 exactly on edge N+12.
  - Required response: phase stays 0 and the next toggle occurs at N+24.
  - Stimulus: write PERIOD=0.
  - Required response: out_port = DATA; STATUS = 0.
- Read latency:
  - Stimulus: hold address=1 and write BLINK_EN=0xAA at edge N.
  - Required response: readdata shows the old value after edge N and 0x000000AA after edge N+1.

Source files
------------

// File: rtl/blockram_system_v2_leds.sv
// -----------------------------------------------------------------------------
// blockram_system_v2_leds
//
// Avalon-MM slave LED output port with atomic set/clear aliases and an
// autonomous per-bit blink engine. Read data comes from a registered read mux,
// so reads have one cycle of latency.
//
// Register map (word addresses):
//   0 DATA      R/W  WIDTH bits
//   1 BLINK_EN  R/W  WIDTH bits
//   2 PERIOD    R/W  16 bits, half-period in blink ticks
//   3 STATUS    R    bit0 = phase, bit1 = (PERIOD != 0)
//   4 OUTSET    W    DATA |=  writedata
//   5 OUTCLEAR  W    DATA &= ~writedata
//   6,7         reserved
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data
//   out_port    LED drive, active-high
// -----------------------------------------------------------------------------
module blockram_system_v2_leds #(
  parameter int unsigned PRESCALE = 50000,  // clk cycles per blink tick, >= 2
  parameter int unsigned WIDTH    = 8       // number of LEDs, 1..16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam int unsigned PW = $clog2(PRESCALE);

  typedef enum logic [2:0] {
    ADDR_DATA     = 3'd0,
    ADDR_BLINK_EN = 3'd1,
    ADDR_PERIOD   = 3'd2,
    ADDR_STATUS   = 3'd3,
    ADDR_OUTSET   = 3'd4,
    ADDR_OUTCLEAR = 3'd5,
    ADDR_RSVD6    = 3'd6,
    ADDR_RSVD7    = 3'd7
  } addr_e;

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] blink_en;
  logic [15:0]      period;
  logic [PW-1:0]    presc;
  logic [15:0]      hcnt;
  logic             phase;
  logic [31:0]      rd_mux;

  logic             wr;
  logic             wr_period;
  logic             period_nz;
  logic             presc_last;
  logic [WIDTH-1:0] wdata;

  assign wr         = chipselect & ~write_n;
  assign wr_period  = wr && (addr_e'(address) == ADDR_PERIOD);
  assign period_nz  = (period != 16'd0);
  assign presc_last = (presc == PW'(PRESCALE - 1));
  assign wdata      = writedata[WIDTH-1:0];

  // Output is a pure function of flops so software-visible state and the pins
  // can never disagree by a cycle.
  assign out_port = data ^ (blink_en & {WIDTH{phase}});

  // Register file. OUTSET/OUTCLEAR are aliases that modify DATA atomically,
  // saving software a read-modify-write.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data     <= '0;
      blink_en <= '0;
      period   <= '0;
    end else if (wr) begin
      case (addr_e'(address))
        ADDR_DATA:     data     <= wdata;
        ADDR_BLINK_EN: blink_en <= wdata;
        ADDR_PERIOD:   period   <= writedata[15:0];
        ADDR_OUTSET:   data     <= data | wdata;
        ADDR_OUTCLEAR: data     <= data & ~wdata;
        default:       ;  // STATUS is read-only, 6/7 reserved
      endcase
    end
  end

  // Blink engine. A PERIOD write restarts the half-period from scratch and
  // takes priority over a toggle due on the same edge; PERIOD=0 parks the
  // engine with phase low so out_port shows DATA unmodified.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      hcnt  <= '0;
      phase <= 1'b0;
    end else if (wr_period || !period_nz) begin
      presc <= '0;
      hcnt  <= '0;
      phase <= 1'b0;
    end else if (presc_last) begin
      presc <= '0;
      if (hcnt == period - 16'd1) begin
        hcnt  <= '0;
        phase <= ~phase;
      end else begin
        hcnt <= hcnt + 16'd1;
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Read mux, sampled every edge from the current address (no read strobe).
  // NOTE: rd_mux gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_mux = '0;
    case (addr_e'(address))
      ADDR_DATA:     rd_mux = 32'(data);
      ADDR_BLINK_EN: rd_mux = 32'(blink_en);
      ADDR_PERIOD:   rd_mux = {16'd0, period};
      ADDR_STATUS:   rd_mux = {30'd0, period_nz, phase};
      default:       rd_mux = '0;  // write-only aliases and reserved read 0
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_blockram_system_v2_leds.sv
module tb_blockram_system_v2_leds;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned WIDTH    = 8;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [WIDTH-1:0] out_port;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  blockram_system_v2_leds #(.PRESCALE(PRESCALE), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: registers plus a count of edges since the last PERIOD
  // write; phase is derived arithmetically from elapsed time.
  // ---------------------------------------------------------------------------
  logic [7:0]  m_data, m_en;
  logic [15:0] m_period;
  int unsigned m_cnt;
  logic [31:0] m_rd;

  function automatic logic m_phase();
    if (m_period == 16'd0) return 1'b0;
    return ((m_cnt / (32'(m_period) * PRESCALE)) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_data};
      3'd1: return {24'd0, m_en};
      3'd2: return {16'd0, m_period};
      3'd3: return {30'd0, (m_period != 16'd0), m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data <= '0; m_en <= '0; m_period <= '0; m_cnt <= 0; m_rd <= '0;
    end else begin
      m_rd  <= m_read(address);
      m_cnt <= m_cnt + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data <= writedata[7:0];
          3'd1: m_en   <= writedata[7:0];
          3'd2: begin m_period <= writedata[15:0]; m_cnt <= 0; end
          3'd4: m_data <= m_data | writedata[7:0];
          3'd5: m_data <= m_data & ~writedata[7:0];
          default: ;
        endcase
      end
    end
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_out_port", 32'(out_port), 32'(m_data ^ (m_en & {8{m_phase()}})));
      check("cyc_readdata", readdata, m_rd);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = a;
    @(negedge clk);
    check(name, readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    check("reset_out_port", 32'(out_port), 32'h0);
    check("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    cmp_on  = 1'b1;

    // Write/readback and set/clear
    wr(3'd0, 32'h5A); check("data_5a", 32'(out_port), 32'h5A);
    wr(3'd4, 32'h81); check("outset",  32'(out_port), 32'hDB);
    wr(3'd5, 32'h18); check("outclr",  32'(out_port), 32'hC3);
    rd(3'd0, 32'hC3, "rd_data_c3");
    rd(3'd4, 32'h0,  "rd_outset");
    rd(3'd5, 32'h0,  "rd_outclr");

    // Width masking and reserved addresses
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, 32'h0000_00FF, "rd_mask");
    wr(3'd6, 32'h1234_5678);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd0, 32'hFF, "rsvd_data");
    rd(3'd1, 32'h0,  "rsvd_en");
    rd(3'd2, 32'h0,  "rsvd_period");
    rd(3'd6, 32'h0,  "rd_6");
    rd(3'd7, 32'h0,  "rd_7");

    // Blink timing: PERIOD=3 at edge N, toggles at N+12 and N+24
    wr(3'd0, 32'h0F);
    wr(3'd1, 32'h03);
    wr(3'd2, 32'd3);          // returns just after edge N
    address = 3'd3;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 11) check("blink_pre",   32'(out_port), 32'h0F);
      if (k == 12) check("blink_on",    32'(out_port), 32'h0C);
      if (k == 13) check("status_ph1",  readdata,      32'h3);
      if (k == 23) check("blink_hold",  32'(out_port), 32'h0C);
      if (k == 24) check("blink_off",   32'(out_port), 32'h0F);
    end

    // PERIOD rewrite on the toggle edge: write wins, next toggle 12 later
    wr(3'd2, 32'd3);          // edge M
    repeat (10) @(negedge clk);
    wr(3'd2, 32'd3);          // edge M+12
    check("collide_ph0", 32'(out_port), 32'h0F);
    repeat (11) @(negedge clk);
    check("collide_pre", 32'(out_port), 32'h0F);
    @(negedge clk);
    check("collide_tog", 32'(out_port), 32'h0C);

    // PERIOD=0 parks the engine
    wr(3'd2, 32'd0);
    check("period0_out", 32'(out_port), 32'h0F);
    rd(3'd3, 32'h0, "period0_status");

    // Read latency with address held
    @(negedge clk); address = 3'd1;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; writedata = 32'hAA;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    check("lat_old", readdata, 32'h03);
    @(negedge clk);
    check("lat_new", readdata, 32'hAA);

    // Reset mid-blink
    wr(3'd0, 32'hFF);
    wr(3'd2, 32'd1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_out_port", 32'(out_port), 32'h0);
    check("async_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, "post_reset_rd");

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
